// File: rtl/neuron_mac_engine.sv
// Neuron dot-product engine: LANES pixel x weight products per beat, three-stage MAC pipeline,
// saturated signed result. Define NEURON_MAC_RELU_EN to clamp negative results to zero.
module neuron_mac_engine #(
  parameter int unsigned N_INPUTS = 784,
  parameter int unsigned LANES    = 4,
  parameter int unsigned PIX_W    = 10,
  parameter int unsigned WGT_W    = 19,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned OUT_W    = 26
) (
  input  logic                     clk,
  input  logic                     GlobalReset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   pixels,
  input  logic [LANES*WGT_W-1:0]   weights,
  output logic [OUT_W-1:0]         result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy
);

  localparam int unsigned PROD_W = PIX_W + WGT_W + 1;
  localparam int unsigned BEATS  = N_INPUTS / LANES;
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [PROD_W-1:0]  pix_ext [LANES];
  logic signed [PROD_W-1:0]  wgt_ext [LANES];
  logic signed [PROD_W-1:0]  prod_d  [LANES];
  logic signed [PROD_W-1:0]  prod_q  [LANES];
  logic                      s1_valid_q, s2_valid_q;
  logic signed [ACC_W-1:0]   sum_d, sum_q;
  logic signed [ACC_W-1:0]   acc_d, acc_q;
  logic [OUT_W-1:0]          sat_val, res_val;
  logic [OUT_W-1:0]          result_q, result_d;
  logic                      accept;

  assign accept = in_valid && (state_q == StAccum);

  // Stage 1: zero-extended pixel times sign-extended weight.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      pix_ext[k] = PROD_W'(pixels[k*PIX_W +: PIX_W]);
      wgt_ext[k] = PROD_W'($signed(weights[k*WGT_W +: WGT_W]));
      prod_d[k]  = pix_ext[k] * wgt_ext[k];
    end
  end

  // Stage 2: lane reduction.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_d = sum_d + ACC_W'(prod_q[k]);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == StIdle && start) begin
      acc_d = '0;
    end else if (s2_valid_q) begin
      acc_d = acc_q + sum_q;
    end
  end

  always_comb begin
    if (acc_d > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (acc_d < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_val = acc_d[OUT_W-1:0];
    end
`ifdef NEURON_MAC_RELU_EN
    res_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Stage 1 empty means the last sum lands in the accumulator this cycle.
        if (!s1_valid_q) begin
          state_d  = StDone;
          result_d = res_val;
        end
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
    end
  end

  assign in_ready     = (state_q == StAccum);
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = result_q;

endmodule
